// File: rtl/dmem_lsu.sv
// Single-port data memory with byte/half/word load-store unit, single-cycle completion,
// and a power-on sweep that fills every word with INIT_VALUE before requests are accepted.
`default_nettype none

module dmem_lsu #(
    parameter int          MEM_DEPTH     = 1024,
    parameter logic [31:0] INIT_VALUE    = 32'hFFFF_FFFF,
    parameter bit          INIT_ON_RESET = 1'b1,
    localparam int         AW            = $clog2(MEM_DEPTH) + 2
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          unsigned_ld,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          rvalid,
    output logic [31:0]   rdata,
    output logic          err
);

    localparam int IW = AW - 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_q [MEM_DEPTH];

    logic          accept;
    logic          misaligned;
    logic          store_en;
    logic [IW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   word_rd;
    logic [31:0]   shifted;
    logic [31:0]   ld_val;

    assign ready    = (state_q == ST_RUN);
    assign accept   = req && ready;
    assign idx      = addr[AW-1:2];
    assign store_en = accept && we && !misaligned;
    assign word_rd  = mem_q[idx];
    assign shifted  = word_rd >> {addr[1:0], 3'b000};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IW'(MEM_DEPTH - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        misaligned = 1'b0;
        be         = 4'b0000;
        wlanes     = wdata;
        ld_val     = word_rd;
        case (size)
            2'b00: begin
                be     = 4'b0001 << addr[1:0];
                wlanes = {4{wdata[7:0]}};
                ld_val = unsigned_ld ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                misaligned = addr[0];
                be         = addr[1] ? 4'b1100 : 4'b0011;
                wlanes     = {2{wdata[15:0]}};
                ld_val     = unsigned_ld ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            2'b10: begin
                misaligned = |addr[1:0];
                be         = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Stores and faulting accesses complete with zero data; idle cycles hold rdata.
    always_comb begin
        rvalid_d = accept;
        err_d    = accept && misaligned;
        rdata_d  = rdata_q;
        if (accept) begin
            rdata_d = (misaligned || we) ? 32'h0 : ld_val;
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q  <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage has no reset; writes are suppressed while RESET is held low.
    always_ff @(posedge clk) begin
        if (RESET) begin
            if (state_q == ST_INIT) begin
                mem_q[cnt_q] <= INIT_VALUE;
            end else if (store_en) begin
                for (int l = 0; l < 4; l++) begin
                    if (be[l]) begin
                        mem_q[idx][8*l +: 8] <= wlanes[8*l +: 8];
                    end
                end
            end
        end
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// Directed scoreboard bench for dmem_lsu (MEM_DEPTH=16): init sweep, lane
// extraction/extension, misalignment faults, back-to-back hazards, and reset recovery.
`default_nettype none

module tb_dmem_lsu;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH) + 2;

    logic          clk = 1'b0;
    logic          RESET = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    size = 2'b10;
    logic          unsigned_ld = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = 32'h0;
    logic          ready;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] last_rdata = 32'h0;

    dmem_lsu #(
        .MEM_DEPTH    (DEPTH),
        .INIT_VALUE   (32'hFFFF_FFFF),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .req        (req),
        .we         (we),
        .size       (size),
        .unsigned_ld(unsigned_ld),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check whatever the DUT presents there.
    task automatic tick();
        logic [32:0] e;
        string       t;
        @(negedge clk);
        if (!RESET) begin
            chk32("reset_rvalid", {31'h0, rvalid}, 32'h0);
            chk32("reset_err",    {31'h0, err},    32'h0);
            chk32("reset_rdata",  rdata,           32'h0);
            chk32("reset_ready",  {31'h0, ready},  32'h0);
            last_rdata = 32'h0;
        end else if (rvalid) begin
            if (exp_q.size() == 0) begin
                chk32("spurious_rvalid", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk32({t, "_rdata"}, rdata, e[31:0]);
                chk32({t, "_err"}, {31'h0, err}, {31'h0, e[32]});
            end
            last_rdata = rdata;
        end else begin
            chk32("idle_err",  {31'h0, err}, 32'h0);
            chk32("idle_hold", rdata, last_rdata);
        end
    endtask

    task automatic issue(input string tag, input logic w, input logic [1:0] sz,
                         input logic uns, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e);
        req         = 1'b1;
        we          = w;
        size        = sz;
        unsigned_ld = uns;
        addr        = a;
        wdata       = d;
        exp_q.push_back({exp_e, exp_d});
        tag_q.push_back(tag);
        tick();
        req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        chk32("drain_empty", exp_q.size(), 32'h0);
    endtask

    // Requests are held high through the sweep; any completion would be spurious.
    task automatic wait_ready(input string tag);
        int n = 0;
        req  = 1'b1;
        we   = 1'b1;
        size = 2'b10;
        addr = '0;
        wdata = 32'h0;
        do begin
            tick();
            n++;
        end while (!ready && n < 100);
        req = 1'b0;
        chk32(tag, n, DEPTH);
    endtask

    initial begin
        repeat (3) tick();
        RESET = 1'b1;
        wait_ready("sweep_cycles");

        for (int i = 0; i < DEPTH; i++) begin
            issue("init_word", 1'b0, 2'b10, 1'b0, AW'(i * 4), 32'h0, 32'hFFFF_FFFF, 1'b0);
        end
        tick();

        issue("st_word10",  1'b1, 2'b10, 1'b0, 6'h10, 32'h8765_4321, 32'h0, 1'b0);
        issue("ldb13_s",    1'b0, 2'b00, 1'b0, 6'h13, 32'h0, 32'hFFFF_FF87, 1'b0);
        issue("ldb13_u",    1'b0, 2'b00, 1'b1, 6'h13, 32'h0, 32'h0000_0087, 1'b0);
        issue("ldh12_s",    1'b0, 2'b01, 1'b0, 6'h12, 32'h0, 32'hFFFF_8765, 1'b0);
        issue("ldh10_u",    1'b0, 2'b01, 1'b1, 6'h10, 32'h0, 32'h0000_4321, 1'b0);
        issue("ldb10_s",    1'b0, 2'b00, 1'b0, 6'h10, 32'h0, 32'h0000_0021, 1'b0);
        issue("ldw10_uns",  1'b0, 2'b10, 1'b1, 6'h10, 32'h0, 32'h8765_4321, 1'b0);
        tick();

        issue("st_byte21",  1'b1, 2'b00, 1'b0, 6'h21, 32'h1234_56AB, 32'h0, 1'b0);
        issue("ldw20",      1'b0, 2'b10, 1'b0, 6'h20, 32'h0, 32'hFFFF_ABFF, 1'b0);
        issue("st_half2a",  1'b1, 2'b01, 1'b0, 6'h2A, 32'h5555_BEEF, 32'h0, 1'b0);
        issue("ldw28",      1'b0, 2'b10, 1'b0, 6'h28, 32'h0, 32'hBEEF_FFFF, 1'b0);
        tick();

        issue("mis_ldh05",  1'b0, 2'b01, 1'b0, 6'h05, 32'h0, 32'h0, 1'b1);
        issue("mis_stw06",  1'b1, 2'b10, 1'b0, 6'h06, 32'h0, 32'h0, 1'b1);
        issue("mis_st11",   1'b1, 2'b11, 1'b0, 6'h04, 32'h0, 32'h0, 1'b1);
        issue("mis_ld11",   1'b0, 2'b11, 1'b0, 6'h04, 32'h0, 32'h0, 1'b1);
        issue("ldw04_kept", 1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 32'hFFFF_FFFF, 1'b0);
        tick();

        issue("b2b_st3c",   1'b1, 2'b10, 1'b0, 6'h3C, 32'h1234_5678, 32'h0, 1'b0);
        chk32("b2b_rvalid_n1", {31'h0, rvalid}, 32'h1);
        issue("b2b_ld3c",   1'b0, 2'b10, 1'b0, 6'h3C, 32'h0, 32'h1234_5678, 1'b0);
        tick();
        drain();

        // Reset partway through a sweep.
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        repeat (5) tick();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        wait_ready("sweep_after_mid_reset");

        // Reset with a load in flight: its completion must be dropped.
        req = 1'b1; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 6'h3C;
        @(posedge clk);
        #1;
        RESET = 1'b0;
        req   = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        wait_ready("sweep_after_inflight_reset");

        issue("ldw3c_reinit", 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0, 32'hFFFF_FFFF, 1'b0);
        tick();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
